// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the core controller and the shift sequencer.
// The abort input exists only when SHIFT_SEQUENCER_ABORT_EN is defined.
interface shift_sequencer_if #(
    parameter int N  = 32,
    parameter int SW = 5
);
    logic          start;
    logic [1:0]    op;
    logic [SW-1:0] shamt;
    logic [N-1:0]  a;
    logic          busy;
    logic          done;
    logic [N-1:0]  z;
`ifdef SHIFT_SEQUENCER_ABORT_EN
    logic          abort;

    modport master (output start, op, shamt, a, abort, input busy, done, z);
    modport slave  (input start, op, shamt, a, abort, output busy, done, z);
`else
    modport master (output start, op, shamt, a, input busy, done, z);
    modport slave  (input start, op, shamt, a, output busy, done, z);
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA engine: one shared stage shifts by 2 (or 1 for the odd tail) per cycle.
// Optional SHIFT_SEQUENCER_ABORT_EN adds an abort input that cancels an operation in SHIFT.
module shift_sequencer #(
    parameter int N  = 32,
    parameter int SW = 5
) (
    input logic               clk,
    input logic               rst_n,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, next;
    logic [N-1:0]  data, data_step, z_q;
    logic [SW-1:0] rem, rem_step;
    logic [1:0]    op_q;
    logic          accept, step_two, abort_hit;
    logic signed [N-1:0] sdata;

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign step_two = rem > SW'(1);
    assign rem_step = step_two ? rem - SW'(2) : rem - SW'(1);
    assign sdata    = data;

`ifdef SHIFT_SEQUENCER_ABORT_EN
    assign abort_hit = bus.abort && (state == SHIFT);
`else
    assign abort_hit = 1'b0;
`endif

    // op 2'b11 is reserved and falls through to SLL
    always_comb begin
        data_step = step_two ? data << 2 : data << 1;
        case (op_q)
            2'b01:   data_step = step_two ? data >> 2 : data >> 1;
            2'b10:   data_step = step_two ? N'(sdata >>> 2) : N'(sdata >>> 1);
            default: data_step = step_two ? data << 2 : data << 1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (bus.start) next = (bus.shamt == '0) ? DONE : SHIFT;
            SHIFT: begin
                if (abort_hit)             next = IDLE;
                else if (rem_step == '0)   next = DONE;
            end
            DONE:    next = bus.start ? ((bus.shamt == '0) ? DONE : SHIFT) : IDLE;
            default: next = IDLE;
        endcase
    end

    // z loads only on entry to DONE: from the final step, or straight from a when shamt==0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            rem  <= '0;
            op_q <= '0;
            z_q  <= '0;
        end else begin
            if (accept) begin
                data <= bus.a;
                rem  <= bus.shamt;
                op_q <= bus.op;
            end else if (state == SHIFT && !abort_hit) begin
                data <= data_step;
                rem  <= rem_step;
            end
            if (next == DONE) z_q <= (state == SHIFT) ? data_step : bus.a;
        end
    end

    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = (state == DONE);
        bus.z    = z_q;
    end
endmodule
